afifo_rd_stream: RTL and testbench

- Read-side consumer of the team's asynchronous FIFO; sits directly downstream of its read port in the TX datapath.
- Pops framed words (sop/eop/payload) from the FIFO and presents them as a valid/ready packet stream.
- Uses a 2-entry output buffer to keep full throughput under backpressure.
- Enforces packet framing: drops stray beats, flags truncated packets, and counts packets and errors.

---
 rtl/afifo_pkg.sv | 20 ++
 rtl/stream_skid_buf.sv | 57 +++++
 rtl/afifo_rd_stream.sv | 118 +++++++++++
 tb/tb_afifo_rd_stream.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/afifo_pkg.sv
// Shared constants and types for the async-FIFO read-side stream logic.
// Word layout: [w-1] = sop, [w-2] = eop, remaining low bits = payload.
package afifo_pkg;

    localparam int unsigned ERR_CNT_W = 8;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_IN_PKT = 1'b1
    } frame_st_e;

    function automatic int unsigned sop_bit(input int unsigned width_data);
        return width_data - 1;
    endfunction

    function automatic int unsigned eop_bit(input int unsigned width_data);
        return width_data - 2;
    endfunction

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry valid/ready buffer in strict FIFO order; the head entry drives data_o.
module stream_skid_buf #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [Width-1:0] push_data_i,
    input  logic             ready_i,
    output logic             valid_o,
    output logic [Width-1:0] data_o,
    output logic [1:0]       occ_o
);

    logic [Width-1:0] head_q, tail_q;
    logic [1:0]       occ_q;
    logic             pop;

    assign valid_o = (occ_q != 2'd0);
    assign pop     = valid_o && ready_i;
    assign data_o  = head_q;
    assign occ_o   = occ_q;

    // The producer never pushes into a full buffer unless it also pops.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            head_q <= '0;
            tail_q <= '0;
            occ_q  <= 2'd0;
        end else begin
            case ({push_i, pop})
                2'b10: begin
                    if (occ_q == 2'd0) begin
                        head_q <= push_data_i;
                    end else begin
                        tail_q <= push_data_i;
                    end
                    occ_q <= occ_q + 2'd1;
                end
                2'b01: begin
                    head_q <= tail_q;
                    occ_q  <= occ_q - 2'd1;
                end
                2'b11: begin
                    if (occ_q == 2'd1) begin
                        head_q <= push_data_i;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= push_data_i;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/afifo_rd_stream.sv
// Pops framed words from the async FIFO read port and emits a valid/ready packet
// stream, dropping stray beats and flagging truncated packets.
module afifo_rd_stream
    import afifo_pkg::*;
#(
    parameter int unsigned WIDTH_DATA = 36,
    parameter bit          SHOW_AHEAD = 1'b1,
    parameter int unsigned WIDTH_CNT  = 16
) (
    input  logic                  rdclock,
    input  logic                  rd_rst_n,
    input  logic [WIDTH_DATA-1:0] fifo_rdata,
    input  logic                  fifo_empty,
    output logic                  fifo_ren,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [WIDTH_DATA-3:0] m_data,
    output logic                  m_sop,
    output logic                  m_eop,
    output logic                  m_err,
    output logic                  err_frame,
    output logic [ERR_CNT_W-1:0]  err_cnt,
    output logic [WIDTH_CNT-1:0]  pkt_cnt
);

    localparam int unsigned SOP_BIT = sop_bit(WIDTH_DATA);
    localparam int unsigned EOP_BIT = eop_bit(WIDTH_DATA);
    localparam int unsigned PAY_W   = WIDTH_DATA - 2;
    localparam int unsigned ENTRY_W = PAY_W + 3;

    frame_st_e            state_q;
    logic                 infl_q;
    logic                 err_frame_q;
    logic [ERR_CNT_W-1:0] err_cnt_q;
    logic [WIDTH_CNT-1:0] pkt_cnt_q;

    logic [1:0]           occ;
    logic [2:0]           budget;
    logic                 pop;
    logic                 cap_valid;
    logic                 cap_sop;
    logic                 cap_eop;
    logic                 fwd;
    logic                 frame_err;
    logic [ENTRY_W-1:0]   push_entry;
    logic [ENTRY_W-1:0]   head_entry;

    assign pop    = m_valid && m_ready;
    // Slots already spoken for: buffered beats plus a read still on its way.
    assign budget = {1'b0, occ} + {2'b00, infl_q} - {2'b00, pop};

    assign fifo_ren  = rd_rst_n && !fifo_empty && (budget < 3'd2);
    assign cap_valid = SHOW_AHEAD ? fifo_ren : infl_q;
    assign cap_sop   = fifo_rdata[SOP_BIT];
    assign cap_eop   = fifo_rdata[EOP_BIT];

    always_comb begin
        fwd       = 1'b0;
        frame_err = 1'b0;
        if (cap_valid) begin
            case (state_q)
                ST_IDLE: begin
                    fwd       = cap_sop;
                    frame_err = !cap_sop;
                end
                ST_IN_PKT: begin
                    fwd       = 1'b1;
                    frame_err = cap_sop;
                end
                default: ;
            endcase
        end
    end

    // A forwarded word only carries frame_err when it is a sop cutting a packet short.
    assign push_entry = {frame_err, cap_sop, cap_eop, fifo_rdata[PAY_W-1:0]};

    always_ff @(posedge rdclock) begin
        if (!rd_rst_n) begin
            state_q     <= ST_IDLE;
            infl_q      <= 1'b0;
            err_frame_q <= 1'b0;
            err_cnt_q   <= '0;
            pkt_cnt_q   <= '0;
        end else begin
            infl_q      <= !SHOW_AHEAD && fifo_ren;
            err_frame_q <= frame_err;
            if (frame_err && (err_cnt_q != '1)) begin
                err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
            end
            if (pop && m_eop) begin
                pkt_cnt_q <= pkt_cnt_q + WIDTH_CNT'(1);
            end
            if (fwd) begin
                state_q <= cap_eop ? ST_IDLE : ST_IN_PKT;
            end
        end
    end

    stream_skid_buf #(
        .Width (ENTRY_W)
    ) u_skid_buf (
        .clk_i       (rdclock),
        .rst_ni      (rd_rst_n),
        .push_i      (fwd && rd_rst_n),
        .push_data_i (push_entry),
        .ready_i     (m_ready),
        .valid_o     (m_valid),
        .data_o      (head_entry),
        .occ_o       (occ)
    );

    assign {m_err, m_sop, m_eop, m_data} = head_entry;
    assign err_frame = err_frame_q;
    assign err_cnt   = err_cnt_q;
    assign pkt_cnt   = pkt_cnt_q;

endmodule

// File: tb/tb_afifo_rd_stream.sv
// Bench for afifo_rd_stream: one instance per SHOW_AHEAD mode, both fed the same word
// stream, checked against a word-level framing model and per-beat scoreboard.
module tb_afifo_rd_stream;

    localparam int W  = 36;
    localparam int PW = W - 2;
    localparam int EW = PW + 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic [1:0]     m_ready, stall;
    logic [1:0]     fifo_ren, fifo_empty, m_valid, m_sop, m_eop, m_err, err_frame;
    logic [W-1:0]   fifo_rdata [2];
    logic [PW-1:0]  m_data [2];
    logic [7:0]     err_cnt [2];
    logic [15:0]    pkt_cnt [2];

    logic [W-1:0]   src_mem [0:1023];
    int             src_n = 0;
    logic [EW-1:0]  exp_mem [0:2047];
    int             exp_n = 0;
    bit             model_in_pkt = 1'b0;
    int             exp_err = 0;
    int             exp_pkt = 0;
    bit             mon_en = 1'b0;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    int first_ren [2], last_ren [2], ren_cnt [2], first_val [2], val_cnt [2];
    int first_pop [2], last_pop [2], pop_cnt [2], efr_cnt [2];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic int sat_err(input int e);
        return (e > 255) ? 255 : e;
    endfunction

    // Reference: every word goes through the FIFO in order; framing rules decide its fate.
    task automatic push_word(input bit sop, input bit eop);
        logic [PW-1:0] pay;
        bit            err;
        pay = PW'({$urandom, $urandom});
        src_mem[src_n] = {sop, eop, pay};
        src_n++;
        if (!model_in_pkt && !sop) begin
            exp_err++;
        end else begin
            err = sop && model_in_pkt;
            if (err) exp_err++;
            exp_mem[exp_n] = {err, sop, eop, pay};
            exp_n++;
            if (eop) exp_pkt++;
            model_in_pkt = !eop;
        end
    endtask

    task automatic observe(input int n, input bit rnd);
        for (int k = 0; k < 2; k++) begin
            first_ren[k] = -1; last_ren[k] = -1; ren_cnt[k] = 0; first_val[k] = -1;
            val_cnt[k] = 0; first_pop[k] = -1; last_pop[k] = -1; pop_cnt[k] = 0;
            efr_cnt[k] = 0;
        end
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            for (int k = 0; k < 2; k++) begin
                if (fifo_ren[k]) begin
                    if (first_ren[k] < 0) first_ren[k] = c;
                    last_ren[k] = c;
                    ren_cnt[k]++;
                end
                if (m_valid[k]) begin
                    if (first_val[k] < 0) first_val[k] = c;
                    val_cnt[k]++;
                end
                if (m_valid[k] && m_ready[k]) begin
                    if (first_pop[k] < 0) first_pop[k] = c;
                    last_pop[k] = c;
                    pop_cnt[k]++;
                end
                if (err_frame[k]) efr_cnt[k]++;
            end
            @(posedge clk);
            #1;
            if (rnd) begin
                m_ready = 2'($urandom);
                stall   = {($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0)};
            end
        end
    endtask

    for (genvar k = 0; k < 2; k++) begin : g_dut
        int            rp = 0;
        int            pi = 0;
        logic [W-1:0]  rdq = '0;
        logic          held = 1'b0;
        logic [EW-1:0] prev = '0;
        logic [EW-1:0] beat;

        // k = 0 models a show-ahead FIFO, k = 1 a registered-read FIFO.
        assign fifo_empty[k] = stall[k] || (rp >= src_n);
        assign fifo_rdata[k] = (k == 0) ? src_mem[rp] : rdq;

        always @(posedge clk) begin
            if (fifo_ren[k]) begin
                rdq <= src_mem[rp];
                rp  <= rp + 1;
            end
        end

        afifo_rd_stream #(
            .WIDTH_DATA (W),
            .SHOW_AHEAD (k == 0),
            .WIDTH_CNT  (16)
        ) u_dut (
            .rdclock    (clk),
            .rd_rst_n   (rst_n),
            .fifo_rdata (fifo_rdata[k]),
            .fifo_empty (fifo_empty[k]),
            .fifo_ren   (fifo_ren[k]),
            .m_valid    (m_valid[k]),
            .m_ready    (m_ready[k]),
            .m_data     (m_data[k]),
            .m_sop      (m_sop[k]),
            .m_eop      (m_eop[k]),
            .m_err      (m_err[k]),
            .err_frame  (err_frame[k]),
            .err_cnt    (err_cnt[k]),
            .pkt_cnt    (pkt_cnt[k])
        );

        assign beat = {m_err[k], m_sop[k], m_eop[k], m_data[k]};

        always @(negedge clk) begin
            if (mon_en) begin
                if (fifo_ren[k]) chk((k == 0) ? "ren_empty0" : "ren_empty1", fifo_empty[k], 0);
                if (held) chk((k == 0) ? "hold0" : "hold1", {m_valid[k], beat}, {1'b1, prev});
                if (m_valid[k] && m_ready[k]) begin
                    chk((k == 0) ? "beat0" : "beat1", {1'b0, beat},
                        (pi < exp_n) ? {1'b0, exp_mem[pi]} : {1'b1, {EW{1'b0}}});
                    pi <= pi + 1;
                end
                held <= m_valid[k] && !m_ready[k];
                prev <= beat;
            end else begin
                held <= 1'b0;
            end
        end
    end

    initial begin
        int p1 [2];
        rst_n   = 1'b0;
        m_ready = 2'b00;
        stall   = 2'b11;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", m_valid, 0);
        chk("rst_ren", fifo_ren, 0);
        chk("rst_flags", {m_sop, m_eop, m_err, err_frame}, 0);
        chk("rst_cnt", {err_cnt[0], err_cnt[1], pkt_cnt[0], pkt_cnt[1]}, 0);
        chk("rst_data", {m_data[0], m_data[1]}, 0);
        rst_n  = 1'b1;
        mon_en = 1'b1;

        // Four-beat packet, free-flowing output: latency 1 vs 2, no gaps.
        push_word(1, 0); push_word(0, 0); push_word(0, 0); push_word(0, 1);
        stall   = 2'b00;
        m_ready = 2'b11;
        observe(10, 0);
        for (int k = 0; k < 2; k++) begin
            chk("t1_ren_cnt", ren_cnt[k], 4);
            chk("t1_ren_span", last_ren[k] - first_ren[k], 3);
            chk("t1_latency", first_val[k] - first_ren[k], (k == 0) ? 1 : 2);
            chk("t1_pop_cnt", pop_cnt[k], 4);
            chk("t1_pop_span", last_pop[k] - first_pop[k], 3);
            chk("t1_pkt_cnt", pkt_cnt[k], exp_pkt);
            chk("t1_err_cnt", err_cnt[k], sat_err(exp_err));
        end

        // Backpressure mid-packet for five cycles.
        push_word(1, 0);
        for (int i = 0; i < 6; i++) push_word(0, 0);
        push_word(0, 1);
        observe(3, 0);
        p1[0] = pop_cnt[0];
        p1[1] = pop_cnt[1];
        m_ready = 2'b00;
        observe(5, 0);
        for (int k = 0; k < 2; k++) begin
            chk("t3_stall_reads", ren_cnt[k] <= 2, 1);
            chk("t3_stall_pops", pop_cnt[k], 0);
            chk("t3_stall_valid", val_cnt[k], 5);
        end
        m_ready = 2'b11;
        observe(15, 0);
        for (int k = 0; k < 2; k++) chk("t3_total_pops", p1[k] + pop_cnt[k], 8);

        // Stray beat in IDLE, then a single-beat packet.
        push_word(0, 0); push_word(1, 1);
        observe(8, 0);
        for (int k = 0; k < 2; k++) begin
            chk("t4_err_pulse", efr_cnt[k], 1);
            chk("t4_err_cnt", err_cnt[k], sat_err(exp_err));
            chk("t4_pops", pop_cnt[k], 1);
            chk("t4_pkt_cnt", pkt_cnt[k], exp_pkt);
        end

        // Truncated packet: second sop arrives before any eop.
        push_word(1, 0); push_word(0, 0); push_word(1, 0); push_word(0, 1);
        observe(10, 0);
        for (int k = 0; k < 2; k++) begin
            chk("t5_err_pulse", efr_cnt[k], 1);
            chk("t5_err_cnt", err_cnt[k], sat_err(exp_err));
            chk("t5_pkt_cnt", pkt_cnt[k], exp_pkt);
        end

        // Random framing with random backpressure and FIFO starvation.
        for (int i = 0; i < 200; i++) begin
            push_word($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0);
        end
        observe(1500, 1);
        if (model_in_pkt) push_word(0, 1);
        m_ready = 2'b11;
        stall   = 2'b00;
        observe(30, 0);
        chk("rnd_beats0", g_dut[0].pi, exp_n);
        chk("rnd_beats1", g_dut[1].pi, exp_n);
        for (int k = 0; k < 2; k++) begin
            chk("rnd_pkt_cnt", pkt_cnt[k], exp_pkt % 65536);
            chk("rnd_err_cnt", err_cnt[k], sat_err(exp_err));
        end

        // Error counter saturation.
        for (int i = 0; i < 300; i++) push_word(0, 0);
        observe(340, 0);
        for (int k = 0; k < 2; k++) chk("t6_err_sat", err_cnt[k], 255);

        // Reset mid-packet: buffered beats vanish, next non-sop word is a stray.
        mon_en  = 1'b0;
        m_ready = 2'b00;
        push_word(1, 0); push_word(0, 0); push_word(0, 0);
        observe(6, 0);
        for (int k = 0; k < 2; k++) chk("t6_pre_reads", ren_cnt[k], 2);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("t6_rst_valid", m_valid, 0);
        chk("t6_rst_ren", fifo_ren, 0);
        chk("t6_rst_flags", {m_sop, m_eop, m_err, err_frame}, 0);
        chk("t6_rst_cnt", {err_cnt[0], err_cnt[1], pkt_cnt[0], pkt_cnt[1]}, 0);
        chk("t6_rst_data", {m_data[0], m_data[1]}, 0);
        rst_n   = 1'b1;
        m_ready = 2'b11;
        observe(8, 0);
        for (int k = 0; k < 2; k++) begin
            chk("t6_stray_pulse", efr_cnt[k], 1);
            chk("t6_stray_cnt", err_cnt[k], 1);
            chk("t6_stray_pops", pop_cnt[k], 0);
        end
        push_word(1, 1);
        observe(6, 0);
        for (int k = 0; k < 2; k++) begin
            chk("t6_post_pops", pop_cnt[k], 1);
            chk("t6_post_pkt", pkt_cnt[k], 1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
